// File: rtl/starflux_pkg.sv
// Shared types and default constants for the starflux ship logic.
// Holds the ship FSM encoding and the saturating score adder.
package starflux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } ship_state_e;

  localparam logic [3:0] INIT_HEALTH_DEF  = 4'd3;
  localparam logic [7:0] INVULN_TICKS_DEF = 8'd16;
  localparam logic [7:0] KILL_POINTS_DEF  = 8'd1;
  localparam logic [7:0] SCORE_MAX        = 8'hFF;

  // Score addition is done one bit wider so the overflow can be seen and clamped.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator: one-cycle pulse at each 0->1 transition of level.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/ship_status.sv
// Player ship status: health, score and invulnerability window driven by
// hit/kill pulses and grid update ticks.
module ship_status
  import starflux_pkg::*;
#(
  parameter logic [3:0] INIT_HEALTH  = INIT_HEALTH_DEF,
  parameter logic [7:0] INVULN_TICKS = INVULN_TICKS_DEF,
  parameter logic [7:0] KILL_POINTS  = KILL_POINTS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startGameEn,
  input  logic       gridUpdateEn,
  input  logic       hit,
  input  logic       kill,
  output logic [3:0] ship_health,
  output logic [7:0] current_highscore,
  output logic       invuln,
  output logic       dead
);

  ship_state_e state_q, state_d;
  logic [3:0]  health_d;
  logic [7:0]  score_d;
  logic [7:0]  count_q, count_d;
  logic        tick;

  edge_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .level (gridUpdateEn),
    .pulse (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    health_d = ship_health;
    score_d  = current_highscore;
    count_d  = count_q;

    if (startGameEn) begin
      state_d  = ALIVE;
      health_d = INIT_HEALTH;
      score_d  = 8'd0;
      count_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ALIVE: begin
          if (kill) score_d = sat_add(current_highscore, KILL_POINTS);
          if (hit) begin
            if (ship_health > 4'd1) begin
              health_d = ship_health - 4'd1;
              // A zero-length window means hits are never ignored.
              if (INVULN_TICKS != 8'd0) begin
                count_d = INVULN_TICKS;
                state_d = INVULN;
              end
            end else begin
              health_d = 4'd0;
              state_d  = DEAD;
            end
          end
        end
        INVULN: begin
          if (kill) score_d = sat_add(current_highscore, KILL_POINTS);
          if (tick) begin
            if (count_q <= 8'd1) begin
              count_d = 8'd0;
              state_d = ALIVE;
            end else begin
              count_d = count_q - 8'd1;
            end
          end
        end
        DEAD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flag outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      ship_health       <= INIT_HEALTH;
      current_highscore <= 8'd0;
      count_q           <= 8'd0;
      invuln            <= 1'b0;
      dead              <= 1'b0;
    end else begin
      state_q           <= state_d;
      ship_health       <= health_d;
      current_highscore <= score_d;
      count_q           <= count_d;
      invuln            <= (state_d == INVULN);
      dead              <= (state_d == DEAD);
    end
  end

endmodule

// File: tb/tb_ship_status.sv
// Randomised scoreboard bench for ship_status against a game-rule reference model.
module tb_ship_status;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startGameEn = 1'b0;
  logic       gridUpdateEn = 1'b0;
  logic       hit = 1'b0;
  logic       kill = 1'b0;
  logic [3:0] ship_health;
  logic [7:0] current_highscore;
  logic       invuln;
  logic       dead;

  ship_status dut (
    .clk               (clk),
    .reset             (reset),
    .startGameEn       (startGameEn),
    .gridUpdateEn      (gridUpdateEn),
    .hit               (hit),
    .kill              (kill),
    .ship_health       (ship_health),
    .current_highscore (current_highscore),
    .invuln            (invuln),
    .dead              (dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] health;
    logic [7:0] score;
    logic       inv;
    logic       dead;
  } expect_t;

  expect_t sb[$];
  expect_t mon_e;
  int      edge_cnt = 0;
  int      checks = 0;
  int      errors = 0;

  // Reference model: game rules in plain integers.
  int m_health = 3;
  int m_score = 0;
  int m_inv_left = 0;
  bit m_playing = 0;
  bit m_dead = 0;
  bit m_grid_prev = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit g, input bit h, input bit k);
    bit tick;
    if (r) begin
      m_health = 3; m_score = 0; m_inv_left = 0;
      m_playing = 0; m_dead = 0; m_grid_prev = 0;
      return;
    end
    tick = g && !m_grid_prev;
    m_grid_prev = g;
    if (s) begin
      m_playing = 1; m_dead = 0; m_health = 3; m_score = 0; m_inv_left = 0;
    end else if (m_playing && !m_dead) begin
      if (k) m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
      if (m_inv_left > 0) begin
        if (tick) m_inv_left--;
      end else if (h) begin
        if (m_health > 1) begin
          m_health--;
          m_inv_left = 16;
        end else begin
          m_health = 0;
          m_dead = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit g, input bit h, input bit k);
    expect_t e;
    reset = r; startGameEn = s; gridUpdateEn = g; hit = h; kill = k;
    model_update(r, s, g, h, k);
    e.cyc    = edge_cnt + 1;
    e.health = 4'(m_health);
    e.score  = 8'(m_score);
    e.inv    = m_playing && !m_dead && (m_inv_left > 0);
    e.dead   = m_dead;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit g);
    for (int i = 0; i < n; i++) step(0, 0, g, 0, 0);
  endtask

  // Monitor: compares each queued expectation once its clock edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      mon_e = sb.pop_front();
      check("sb_health", {4'd0, ship_health}, {4'd0, mon_e.health});
      check("sb_score", current_highscore, mon_e.score);
      check("sb_invuln", {7'd0, invuln}, {7'd0, mon_e.inv});
      check("sb_dead", {7'd0, dead}, {7'd0, mon_e.dead});
    end
  end

  initial begin
    bit g;
    // Reset, then start.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_health", {4'd0, ship_health}, 8'd3);
    check("reset_dead", {7'd0, dead}, 8'd0);
    step(0, 1, 0, 0, 0);
    check("start_health", {4'd0, ship_health}, 8'd3);
    check("start_score", current_highscore, 8'd0);
    check("start_invuln", {7'd0, invuln}, 8'd0);

    // Hit, then an ignored hit inside the window.
    step(0, 0, 0, 1, 0);
    check("hit_health", {4'd0, ship_health}, 8'd2);
    check("hit_invuln", {7'd0, invuln}, 8'd1);
    idle(4, 0);
    step(0, 0, 0, 1, 0);
    check("inv_hit_ignored", {4'd0, ship_health}, 8'd2);

    // 16 long grid periods; the window closes right after the 16th edge.
    for (int p = 0; p < 16; p++) begin
      step(0, 0, 1, 0, 0);
      check($sformatf("tick_%0d_invuln", p), {7'd0, invuln}, (p == 15) ? 8'd0 : 8'd1);
      idle(99, 1);
      idle(20, 0);
    end

    // Score saturation.
    for (int i = 0; i < 260; i++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    check("score_sat", current_highscore, 8'hFF);

    // Hit and kill together at score 0x10, health 3.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    check("hitkill_score", current_highscore, 8'h11);
    check("hitkill_health", {4'd0, ship_health}, 8'd2);

    // Three hits separated by window expiry lead to DEAD.
    step(0, 1, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 0, 1, 0);
      for (int t = 0; t < 16; t++) begin
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
      end
    end
    check("dead_health", {4'd0, ship_health}, 8'd0);
    check("dead_flag", {7'd0, dead}, 8'd1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    check("dead_frozen_score", current_highscore, 8'd0);
    check("dead_frozen_health", {4'd0, ship_health}, 8'd0);
    step(0, 1, 0, 0, 0);
    check("restart_health", {4'd0, ship_health}, 8'd3);
    check("restart_dead", {7'd0, dead}, 8'd0);

    // Reset beats startGameEn mid-window.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    check("rst_prio_health", {4'd0, ship_health}, 8'd3);
    check("rst_prio_score", current_highscore, 8'd0);
    check("rst_prio_invuln", {7'd0, invuln}, 8'd0);
    step(0, 0, 0, 1, 1);
    check("idle_ignores_kill", current_highscore, 8'd0);

    // Random phase.
    g = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) g = ~g;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0, g,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    idle(2, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_status.md
SHIP_STATUS -- requirements
Module: ship_status

Interface
REQ-001 Parameter INIT_HEALTH, default 4'd3, health loaded on reset and game start.
REQ-002 Parameter INVULN_TICKS, default 8'd16, update ticks of invulnerability after a hit (16 ticks = 1 s at 16 Hz).
REQ-003 Parameter KILL_POINTS, default 8'd1, score added per enemy kill.
REQ-004 clk  input  1  system clock (50 MHz); single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startGameEn  input  1  level; clears game status while high.
REQ-007 gridUpdateEn  input  1  level; held high for a whole update period.
REQ-008 hit  input  1  one-cycle pulse; ship collided with enemy or projectile.
REQ-009 kill  input  1  one-cycle pulse; enemy destroyed by ship fire.
REQ-010 ship_health  output  4  current health; game over when zero.
REQ-011 current_highscore  output  8  current score; saturates at 8'hFF.
REQ-012 invuln  output  1  high while hits are ignored (drives ship blink).
REQ-013 dead  output  1  high in DEAD state.

Function
REQ-014 FSM states: IDLE, ALIVE, INVULN, DEAD; all outputs registered.
REQ-015 tick = one-cycle pulse in the cycle where gridUpdateEn is 1 and its registered previous value is 0; exactly one tick per gridUpdateEn high period.
REQ-016 startGameEn high, any state other than reset: next cycle state=ALIVE, ship_health=INIT_HEALTH, current_highscore=0, invuln counter=0; hit/kill ignored that cycle.
REQ-017 IDLE: hit, kill, tick ignored; leave only via startGameEn.
REQ-018 ALIVE, hit, ship_health>1: ship_health decrements by 1 next cycle; counter loads INVULN_TICKS; state=INVULN (state stays ALIVE if INVULN_TICKS=0).
REQ-019 ALIVE, hit, ship_health==1: ship_health=0 next cycle; state=DEAD.
REQ-020 INVULN: hit ignored; each tick decrements counter; tick with counter==1 returns state to ALIVE next cycle.
REQ-021 invuln=1 exactly when state==INVULN.
REQ-022 kill in ALIVE or INVULN: score += KILL_POINTS, computed 9-bit, clamped to 8'hFF; kill at 8'hFF leaves score unchanged.
REQ-023 hit and kill in same cycle: both applied.
REQ-024 DEAD: ship_health=0 and score frozen; hit, kill, tick ignored; dead=1; exit only via startGameEn or reset.
REQ-025 ship_health never underflows; current_highscore never wraps.
REQ-026 Latency: every hit/kill effect is visible on outputs the cycle after the pulse.

Reset
REQ-027 reset has priority over all inputs, including startGameEn.
REQ-028 On reset: state=IDLE, ship_health=INIT_HEALTH, current_highscore=0, counter=0, invuln=0, dead=0, edge-detect register=0.
REQ-029 reset mid-INVULN or mid-DEAD discards all progress; no pending event survives reset.

Structure
REQ-030 Shared package starflux_pkg holds the state encoding and default constants: INIT_HEALTH, INVULN_TICKS, score max 8'hFF.
REQ-031 One sub-module, edge_detect (rising-edge pulse generator), produces tick from gridUpdateEn; all other logic is in ship_status.
REQ-032 Target size is 120-400 lines of RTL; no memories, no extra clocks.

Verification
REQ-033 Reset, then startGameEn for 1 cycle -> ship_health=3, score=0, state ALIVE, invuln=0, dead=0.
REQ-034 hit pulse in ALIVE -> next cycle ship_health=2, invuln=1; second hit 5 cycles later -> ship_health stays 2.
REQ-035 hit, then 16 gridUpdateEn high periods each 100 cycles high -> invuln falls the cycle after the 16th rising edge; holding gridUpdateEn high yields no extra ticks.
REQ-036 260 kill pulses -> score reaches 8'hFF and holds; hit+kill same cycle at score 8'h10, health 3 -> score 8'h11, health 2.
REQ-037 Three hits separated by invuln expiry -> ship_health=0, dead=1; later kill/hit leave outputs unchanged; startGameEn -> health 3, score 0.
REQ-038 reset asserted during INVULN together with startGameEn -> state IDLE, health 3, score 0, invuln 0 next cycle.
